// File: rtl/mouse_click_ctrl.sv
// Mouse-to-game command controller: edge-detects clicks, hit-tests buttons, issues one command per click.
// Optional right-click CANCEL path enabled by defining MOUSE_RIGHT_CANCEL_EN.
module mouse_click_ctrl #(
    parameter int HIT_X0         = 100,
    parameter int HIT_X1         = 227,
    parameter int STAND_X0       = 300,
    parameter int STAND_X1       = 427,
    parameter int DEAL_X0        = 500,
    parameter int DEAL_X1        = 627,
    parameter int BTN_Y0         = 680,
    parameter int BTN_Y1         = 727,
    parameter int LOCKOUT_CYCLES = 650000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        left,
    input  logic        right,
    input  logic        enable,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [1:0]  cmd,
    output logic        busy
);

    localparam int CW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCKOUT_CYCLES - 1);

    localparam logic [11:0] HX0 = 12'(HIT_X0);
    localparam logic [11:0] HX1 = 12'(HIT_X1);
    localparam logic [11:0] SX0 = 12'(STAND_X0);
    localparam logic [11:0] SX1 = 12'(STAND_X1);
    localparam logic [11:0] DX0 = 12'(DEAL_X0);
    localparam logic [11:0] DX1 = 12'(DEAL_X1);
    localparam logic [11:0] BY0 = 12'(BTN_Y0);
    localparam logic [11:0] BY1 = 12'(BTN_Y1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_REL,
        LOCKOUT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic [11:0] x_q;
    logic [11:0] y_q;
    logic        left_q;
    logic        left_qq;
    logic        press_l;

    logic        in_y;
    logic        hit_h;
    logic        hit_s;
    logic        hit_d;
    logic        hit_any;
    logic [1:0]  hit_cmd;
    logic        rel_lvl;

    function automatic logic in_range(
        input logic [11:0] v,
        input logic [11:0] lo,
        input logic [11:0] hi
    );
        return (v >= lo) && (v <= hi);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q     <= '0;
            y_q     <= '0;
            left_q  <= 1'b0;
            left_qq <= 1'b0;
        end else begin
            x_q     <= xpos;
            y_q     <= ypos;
            left_q  <= left;
            left_qq <= left_q;
        end
    end

    assign press_l = left_q & ~left_qq;

`ifdef MOUSE_RIGHT_CANCEL_EN
    logic right_q;
    logic right_qq;
    logic press_r;
    logic trig_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            right_q  <= 1'b0;
            right_qq <= 1'b0;
        end else begin
            right_q  <= right;
            right_qq <= right_q;
        end
    end

    assign press_r = right_q & ~right_qq;
    assign rel_lvl = trig_r ? right_q : left_q;
`else
    logic unused_right;
    assign unused_right = right;
    assign rel_lvl      = left_q;
`endif

    assign in_y    = in_range(y_q, BY0, BY1);
    assign hit_h   = in_y && in_range(x_q, HX0, HX1);
    assign hit_s   = in_y && in_range(x_q, SX0, SX1);
    assign hit_d   = in_y && in_range(x_q, DX0, DX1);
    assign hit_any = hit_h | hit_s | hit_d;

    // Overlapping rectangles resolve HIT first, then STAND, then DEAL.
    always_comb begin
        hit_cmd = 2'd2;
        if (hit_h)
            hit_cmd = 2'd0;
        else if (hit_s)
            hit_cmd = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            cmd       <= 2'd0;
            busy      <= 1'b0;
            cnt       <= '0;
`ifdef MOUSE_RIGHT_CANCEL_EN
            trig_r    <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (press_l && enable && hit_any) begin
                        cmd       <= hit_cmd;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= REQ;
`ifdef MOUSE_RIGHT_CANCEL_EN
                        trig_r    <= 1'b0;
                    end else if (press_r && enable) begin
                        cmd       <= 2'd3;
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= REQ;
                        trig_r    <= 1'b1;
`endif
                    end
                end
                // The request stays up regardless of enable or button level.
                REQ: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (!rel_lvl) begin
                        cnt   <= LOCK_LOAD;
                        state <= LOCKOUT;
                    end
                end
                LOCKOUT: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mouse_click_ctrl.sv
// Randomized scoreboard bench for mouse_click_ctrl with a timeline reference model.
// Builds with or without MOUSE_RIGHT_CANCEL_EN.
module tb_mouse_click_ctrl;

    localparam int LOCK = 8;
    localparam int MAXE = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] xpos = '0;
    logic [11:0] ypos = '0;
    logic        left = 1'b0;
    logic        right = 1'b0;
    logic        enable = 1'b1;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd;
    logic        busy;

    always #5 clk = ~clk;

    mouse_click_ctrl #(.LOCKOUT_CYCLES(LOCK)) dut (
        .clk      (clk),
        .rst      (rst),
        .xpos     (xpos),
        .ypos     (ypos),
        .left     (left),
        .right    (right),
        .enable   (enable),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd      (cmd),
        .busy     (busy)
    );

    // Input history indexed by the clock edge that samples it.
    bit L_h[MAXE];
    bit R_h[MAXE];
    bit EN_h[MAXE];
    bit RDY_h[MAXE];
    bit RST_h[MAXE];
    int X_h[MAXE];
    int Y_h[MAXE];

    typedef struct {
        int c;
        int t;
    } exp_t;

    exp_t sbq[$];
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_pct = 100;

    bit   m_eng = 0;
    bit   m_trig_r = 0;
    int   m_a, m_h, m_e;
    bit   exp_busy = 0;
    bit   exp_valid = 0;

    function automatic int region(input int x, input int y);
        if (y < 680 || y > 727) return -1;
        if (x >= 100 && x <= 227) return 0;
        if (x >= 300 && x <= 427) return 1;
        if (x >= 500 && x <= 627) return 2;
        return -1;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at edge %0d",
                     name, act, exp, edge_cnt);
        end
    endtask

    // Reference: a click is accepted when the controller is free; it is free
    // again LOCK edges after the first release seen after the handshake.
    task automatic step(input int t);
        bit lp, rp, lvl;
        bit ended;
        int c;
        ended = 0;
        if (RST_h[t]) begin
            m_eng     = 0;
            exp_busy  = 0;
            exp_valid = 0;
            return;
        end
        if (m_eng) begin
            lvl = m_trig_r ? R_h[t-1] : L_h[t-1];
            if (m_h == 0) begin
                if (RDY_h[t]) m_h = t;
            end else if (m_e == 0) begin
                if (!lvl) m_e = t;
            end
            if (m_e != 0 && t == m_e + LOCK) begin
                m_eng = 0;
                ended = 1;
            end
        end
        if (!m_eng && !ended && t >= 2) begin
            lp = L_h[t-1] && !L_h[t-2];
            rp = R_h[t-1] && !R_h[t-2];
            c  = region(X_h[t-1], Y_h[t-1]);
            if (lp && EN_h[t] && c >= 0) begin
                m_eng = 1; m_trig_r = 0;
                m_a = t; m_h = 0; m_e = 0;
                sbq.push_back('{c: c, t: t});
            end
`ifdef MOUSE_RIGHT_CANCEL_EN
            else if (rp && EN_h[t]) begin
                m_eng = 1; m_trig_r = 1;
                m_a = t; m_h = 0; m_e = 0;
                sbq.push_back('{c: 3, t: t});
            end
`else
            if (rp) m_trig_r = 0;
`endif
        end
        exp_busy  = m_eng;
        exp_valid = m_eng && (m_h == 0);
    endtask

    // Called at a negedge with inputs already driven for the next edge.
    task automatic tick();
        int n;
        n = edge_cnt + 1;
        if (n >= MAXE) begin
            $display("FAIL history_overflow: got %0d expected below %0d", n, MAXE);
            $fatal(1);
        end
        cmd_ready = ($urandom_range(0, 99) < rdy_pct);
        RST_h[n] = rst;
        EN_h[n]  = enable;
        RDY_h[n] = cmd_ready;
        L_h[n]   = rst ? 1'b0 : left;
        R_h[n]   = rst ? 1'b0 : right;
        X_h[n]   = rst ? 0 : int'(xpos);
        Y_h[n]   = rst ? 0 : int'(ypos);
        @(posedge clk);
        edge_cnt = n;
        step(n);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic click(input int x, input int y, input int hold,
                         input bit use_l, input bit use_r, input int gap);
        xpos = 12'(x);
        ypos = 12'(y);
        tick();
        left  = use_l;
        right = use_r;
        repeat (hold) tick();
        left  = 1'b0;
        right = 1'b0;
        repeat (gap) tick();
    endtask

    // Monitor: compares busy/valid every cycle and pops the scoreboard on each new command.
    initial begin : monitor
        bit         pv;
        logic [1:0] held;
        exp_t       e;
        pv   = 0;
        held = '0;
        forever begin
            @(negedge clk);
            if (edge_cnt == 0) continue;
            check("busy", int'(busy), int'(exp_busy));
            check("cmd_valid", int'(cmd_valid), int'(exp_valid));
            if (RST_h[edge_cnt]) check("reset_cmd", int'(cmd), 0);
            if (cmd_valid && !pv) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_cmd: got cmd %0d expected none at edge %0d",
                             cmd, edge_cnt);
                end else begin
                    e = sbq.pop_front();
                    check("cmd", int'(cmd), e.c);
                    check("valid_edge", edge_cnt, e.t);
                end
                held = cmd;
            end else if (cmd_valid && pv) begin
                check("cmd_stable", int'(cmd), int'(held));
            end
            pv = cmd_valid;
        end
    end

    int pts_x[12] = '{150, 100, 227, 228, 99, 299, 300, 427, 500, 627, 600, 5};
    int pts_y[12] = '{700, 680, 727, 700, 700, 700, 680, 727, 728, 727, 700, 5};

    initial begin : stim
        int k, btn, hold, gap, x, y;
        @(negedge clk);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // HIT with ready high
        rdy_pct = 100;
        click(150, 700, 3, 1, 0, 20);
        // STAND under backpressure, released while waiting
        rdy_pct = 0;
        click(300, 680, 2, 1, 0, 5);
        rdy_pct = 100;
        idle(20);
        // misses and gating
        click(299, 700, 2, 1, 0, 4);
        click(500, 728, 2, 1, 0, 4);
        enable = 1'b0;
        click(600, 700, 2, 1, 0, 4);
        enable = 1'b1;
        // press during lockout, then held through lockout end
        click(150, 700, 2, 1, 0, 3);
        click(150, 700, 2, 1, 0, 20);
        click(150, 700, 2, 1, 0, 2);
        click(150, 700, 20, 1, 0, 20);
        click(600, 700, 2, 1, 0, 20);
        // reset mid-request
        rdy_pct = 0;
        click(150, 700, 2, 1, 0, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rdy_pct = 100;
        idle(5);
        click(150, 700, 2, 1, 0, 20);
        // right-button paths
        click(5, 5, 2, 0, 1, 20);
        click(150, 700, 2, 1, 1, 20);

        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(0, 13);
            if (k < 12) begin
                x = pts_x[k];
                y = pts_y[k];
            end else begin
                x = $urandom_range(0, 700);
                y = $urandom_range(640, 760);
            end
            btn    = $urandom_range(0, 9);
            hold   = $urandom_range(1, 12);
            gap    = $urandom_range(0, 14);
            enable = ($urandom_range(0, 5) != 0);
            case ($urandom_range(0, 2))
                0: rdy_pct = 30;
                1: rdy_pct = 70;
                default: rdy_pct = 100;
            endcase
            click(x, y, hold, btn < 8, btn >= 7, gap);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end

        enable  = 1'b1;
        rdy_pct = 100;
        idle(40);
        check("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
